// File: rtl/down_timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : down_timer_counter
// Description : Loadable down-counter/timer counting toward zero. Supports
//               one-shot and auto-reload (periodic) operation, a count enable
//               for prescaled ticking, a terminal-count flag and a done flag.
// Ports       : clk          - clock, all state changes on the rising edge
//               reset        - asynchronous, active-high reset
//               load         - capture load_value into reload register and count
//               load_value   - value captured on load
//               start        - begin a count from the reload register
//               stop         - abort a running count, return to IDLE
//               ce           - count enable, RUN advances only when high
//               auto_reload  - 1 = periodic, 0 = one-shot
//               q            - current count
//               tc           - terminal count (RUN and q == 0)
//               running      - high in RUN
//               done         - high in EXPIRED
// Revision    : 1.0 - initial release
// ============================================================================
module down_timer_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             ce,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             w_q_zero;

  assign w_q_zero = (r_q == c_ZERO);

  // Priority order: load > stop > start > count. The state qualifiers on
  // stop (RUN only) and start (not RUN) make those two mutually exclusive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_q      <= c_ZERO;
      r_reload <= c_ZERO;
    end else if (load) begin
      // A load aborts any count in progress.
      r_reload <= load_value;
      r_q      <= load_value;
      r_state  <= ST_IDLE;
    end else if (stop && (r_state == ST_RUN)) begin
      r_state <= ST_IDLE;
    end else if (start && (r_state != ST_RUN)) begin
      // Start always restarts from the reload value; there is no resume.
      r_q     <= r_reload;
      r_state <= ST_RUN;
    end else if ((r_state == ST_RUN) && ce) begin
      if (!w_q_zero) begin
        r_q <= r_q - c_ONE;
      end else if (auto_reload) begin
        // Mode is sampled only here, so it may change mid-count.
        r_q <= r_reload;
      end else begin
        r_state <= ST_EXPIRED;
      end
    end
  end

  // Outputs decode registered state only; no path from inputs.
  assign q       = r_q;
  assign running = (r_state == ST_RUN);
  assign done    = (r_state == ST_EXPIRED);
  assign tc      = (r_state == ST_RUN) && w_q_zero;

endmodule
`default_nettype wire

// File: tb/tb_down_timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_timer_counter
// Description : Self-checking bench for down_timer_counter. Each driven cycle
//               pushes the expected post-edge outputs into a scoreboard queue;
//               a monitor pops and compares them one time unit after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_timer_counter;

  localparam int WIDTH = 4;
  localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_EXP = 2'd2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             ce = 1'b0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] q;
  logic             tc, running, done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             run;
    logic             dn;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0]       m_st = M_IDLE;
  logic [WIDTH-1:0] m_q  = '0;
  logic [WIDTH-1:0] m_rl = '0;

  down_timer_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .ce(ce), .auto_reload(auto_reload),
    .q(q), .tc(tc), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_q",       32'(q),       32'(e.q));
      chk("sb_tc",      32'(tc),      32'(e.tc));
      chk("sb_running", 32'(running), 32'(e.run));
      chk("sb_done",    32'(done),    32'(e.dn));
    end
  end

  // Drive one cycle of stimulus, advance the model, push the expectation.
  task automatic cyc(input logic ld, input logic [WIDTH-1:0] lv, input logic st,
                     input logic sp, input logic c, input logic ar);
    exp_t e;
    load = ld; load_value = lv; start = st; stop = sp; ce = c; auto_reload = ar;
    if (ld) begin
      m_rl = lv; m_q = lv; m_st = M_IDLE;
    end else if (sp && m_st == M_RUN) begin
      m_st = M_IDLE;
    end else if (st && m_st != M_RUN) begin
      m_q = m_rl; m_st = M_RUN;
    end else if (m_st == M_RUN && c) begin
      if (m_q != 0) m_q = m_q - 1'b1;
      else if (ar)  m_q = m_rl;
      else          m_st = M_EXP;
    end
    e.q   = m_q;
    e.tc  = (m_st == M_RUN) && (m_q == 0);
    e.run = (m_st == M_RUN);
    e.dn  = (m_st == M_EXP);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int tc_cnt;
    int dn_cnt;

    // Reset state
    #3;
    chk("rst_q", 32'(q), 0);
    chk("rst_tc", 32'(tc), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #2;

    // 1: one-shot from 3
    cyc(1, 4'd3, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("t1_q_start", 32'(q), 3);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t1_tc_early", 32'(tc), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t1_q0", 32'(q), 0);
    chk("t1_tc", 32'(tc), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_run", 32'(running), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t1_hold_q", 32'(q), 0);

    // 2: periodic from 2, 9 observed cycles
    cyc(1, 4'd2, 0, 0, 0, 1);
    tc_cnt = 0; dn_cnt = 0;
    cyc(0, 0, 1, 0, 1, 1);
    tc_cnt += int'(tc); dn_cnt += int'(done);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      tc_cnt += int'(tc); dn_cnt += int'(done);
    end
    chk("t2_tc_count", 32'(tc_cnt), 3);
    chk("t2_done_never", 32'(dn_cnt), 0);
    chk("t2_q_last", 32'(q), 0);

    // 3: ce gating
    cyc(1, 4'd5, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_q_frozen", 32'(q), 4);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_q3", 32'(q), 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_tc_held", 32'(tc), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t3_done", 32'(done), 1);

    // 4: load aborts a running count
    cyc(1, 4'd7, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t4_q5", 32'(q), 5);
    cyc(1, 4'd1, 0, 0, 1, 0);
    chk("t4_load_q", 32'(q), 1);
    chk("t4_load_run", 32'(running), 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t4_tc", 32'(tc), 1);

    // 6: simultaneous events
    cyc(0, 0, 1, 1, 1, 0);
    chk("t6_stopwins_run", 32'(running), 0);
    chk("t6_stopwins_q", 32'(q), 0);
    cyc(1, 4'd9, 1, 0, 0, 0);
    chk("t6_loadwins_q", 32'(q), 9);
    chk("t6_loadwins_run", 32'(running), 0);
    cyc(1, 4'd1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t6_expired", 32'(done), 1);
    cyc(0, 0, 1, 0, 0, 0);
    chk("t6_restart_run", 32'(running), 1);
    chk("t6_restart_done", 32'(done), 0);
    chk("t6_restart_q", 32'(q), 1);

    // 5: asynchronous reset mid-count
    cyc(1, 4'd4, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t5_q2", 32'(q), 2);
    ce = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("t5_async_q", 32'(q), 0);
    chk("t5_async_run", 32'(running), 0);
    chk("t5_async_tc", 32'(tc), 0);
    chk("t5_async_done", 32'(done), 0);
    m_st = M_IDLE; m_q = '0; m_rl = '0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #2;
    cyc(0, 0, 1, 0, 1, 0);
    chk("t5_tc_now", 32'(tc), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t5_done", 32'(done), 1);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      cyc(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    cyc(0, 0, 0, 0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
